fxp_seq_divider: RTL and testbench
==================================

// Module: fxp_seq_divider
// PURPOSE
//  Sequential signed fixed-point divider: val = a / b, where a, b and val share one Q format (FBITS fractional bits).
//  Responder side of the start/busy/done/valid/dbz handshake used by the attention integer-polynomial datapath.
//  Used for the b/S and c/(a*S^2) terms.
//  Restoring long division, one quotient bit per cycle; one operation in flight.
// PARAMETERS
//  WIDTH  32  total bits of a, b, val (two's complement)
//  FBITS  8   fractional bits of a, b, val
// PORTS
//  clk    in   1      clock
//  rst    in   1      reset, asynchronous, active-high
//  start  in   1      request; sampled only when idle (busy=0)
//  a      in   WIDTH  signed dividend; sampled on the accepted start edge
//  b      in   WIDTH  signed divisor; sampled on the accepted start edge
//  busy   out  1      operation in progress
//  done   out  1      one-cycle completion pulse
//  valid  out  1      val is a correct result (no dbz, no overflow)
//  dbz    out  1      divide by zero detected
//  val    out  WIDTH  signed quotient
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, valid, dbz = 0; val = 0; internal regs = 0. Reset mid-operation aborts it; no done is issued.
//  N = WIDTH+FBITS iterations (40 with defaults).
//  States:
//   - IDLE: start=1 at edge E0 latches operands and goes to CALC; busy=1 from E0.
//   - CALC: at E0, sign = a[MSB]^b[MSB] and dividend = |a|<<FBITS (WIDTH+FBITS bits unsigned).
//     divisor = |b| (WIDTH bits unsigned); |-2^(WIDTH-1)| = 2^(WIDTH-1) with no wrap.
//     Edges E1..EN each shift in one dividend bit (MSB first): rem = {rem, bit}.
//     If rem >= divisor then rem -= divisor and qbit = 1, else qbit = 0.
//     After edge EN the state moves to FIN.
//   - FIN: at edge EN+1, done=1, busy=0, return to IDLE. Outputs:
//     - overflow when quotient magnitude > 2^(WIDTH-1)-1, or > 2^(WIDTH-1) with sign=1.
//     - overflow: valid=0, dbz=0, val=0.
//     - otherwise: valid=1, val = sign ? -q : q. Truncation is toward zero; the remainder is discarded.
//  Divide by zero: b==0 at E0 skips CALC. At E1: done=1, dbz=1, valid=0, val=0, busy=0.
//  done is high for exactly one cycle.
//  val, valid and dbz hold until the next accepted start; that start edge clears valid and dbz.
//  start while busy=1 is ignored; a and b may change freely during busy.
//  start on the same cycle done=1 is accepted (state is IDLE): back-to-back throughput is N+2 cycles.
//  Latency: start edge to done high = N+1 edges (41 with defaults); 1 edge for dbz.
//  Internal widths: rem WIDTH+1 bits, quotient WIDTH+FBITS bits; the overflow check uses the quotient upper bits.
// TESTING (WIDTH=32, FBITS=8)
//  a=0x00000300 (3.0), b=0x00000200 (2.0) -> val=0x00000180, valid=1, dbz=0, done 41 edges after start, busy high 41 cycles.
//  a=0xFFFFFD00 (-3.0), b=0x00000200 -> val=0xFFFFFE80 (-1.5), valid=1; a=0x100, b=0xFFFFFD00 -> val=0xFFFFFFAB.
//  a=0x00000100 (1.0), b=0x00000300 -> val=0x00000055 (truncated); a=0xFFFFFF00 -> val=0xFFFFFFAB (toward zero).
//  b=0, any a -> done one edge after start, dbz=1, valid=0, val=0; a following normal op clears dbz at its start.
//  a=0x7FFFFFFF, b=0x00000001 -> done after 41 edges, valid=0, dbz=0, val=0 (overflow).
//  start pulsed at cycles 5 and 20 of an op -> ignored, one done only; rst at cycle 10 -> outputs 0, no done, next op correct.

Source files
------------

// File: rtl/fxp_seq_divider.sv
// Sequential signed fixed-point divider (val = a / b, shared Q format with FBITS
// fractional bits); restoring long division, one quotient bit per clock.
module fxp_seq_divider #(
  parameter int WIDTH = 32,
  parameter int FBITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             valid,
  output logic             dbz,
  output logic [WIDTH-1:0] val
);

  localparam int N  = WIDTH + FBITS;
  localparam int CW = $clog2(N + 1);

  // Handshake: start is honoured only in IDLE. busy rises on the accepting edge
  // and falls on the edge that raises done. done is a single-cycle pulse.
  // val/valid/dbz hold until the next accepted start, which clears valid and dbz.
  typedef enum logic [1:0] {IDLE, CALC, FIN, DZ} state_t;

  state_t           state, state_nx;
  logic [N-1:0]     dvd_r;
  logic [N-1:0]     quo_r;
  logic [WIDTH:0]   rem_r;
  logic [WIDTH-1:0] dsr_r;
  logic             sign_r;
  logic [CW-1:0]    cnt_r;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   rem_sh, rem_sub;
  logic             ge;
  logic             ovf;
  logic [WIDTH-1:0] q_lo, val_nx;

  // Magnitudes as unsigned WIDTH-bit values, so the most negative input maps to 2^(WIDTH-1).
  assign abs_a = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign abs_b = b[WIDTH-1] ? (~b + 1'b1) : b;

  assign rem_sh  = {rem_r[WIDTH-1:0], dvd_r[N-1]};
  assign ge      = (rem_sh >= {1'b0, dsr_r});
  assign rem_sub = rem_sh - {1'b0, dsr_r};

  // A negative result may reach magnitude 2^(WIDTH-1); a positive one may not.
  assign q_lo   = quo_r[WIDTH-1:0];
  assign ovf    = (|quo_r[N-1:WIDTH]) | (quo_r[WIDTH-1] & (~sign_r | (|quo_r[WIDTH-2:0])));
  assign val_nx = sign_r ? (~q_lo + 1'b1) : q_lo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = (b == '0) ? DZ : CALC;
      CALC: if (cnt_r == CW'(N - 1)) state_nx = FIN;
      FIN:  state_nx = IDLE;
      DZ:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      valid  <= 1'b0;
      dbz    <= 1'b0;
      val    <= '0;
      dvd_r  <= '0;
      quo_r  <= '0;
      rem_r  <= '0;
      dsr_r  <= '0;
      sign_r <= 1'b0;
      cnt_r  <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            busy   <= 1'b1;
            valid  <= 1'b0;
            dbz    <= 1'b0;
            sign_r <= a[WIDTH-1] ^ b[WIDTH-1];
            dvd_r  <= {abs_a, {FBITS{1'b0}}};
            dsr_r  <= abs_b;
            rem_r  <= '0;
            quo_r  <= '0;
            cnt_r  <= '0;
          end
        end
        CALC: begin
          rem_r <= ge ? rem_sub : rem_sh;
          quo_r <= {quo_r[N-2:0], ge};
          dvd_r <= {dvd_r[N-2:0], 1'b0};
          cnt_r <= cnt_r + CW'(1);
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          valid <= ~ovf;
          val   <= ovf ? '0 : val_nx;
        end
        DZ: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          dbz   <= 1'b1;
          valid <= 1'b0;
          val   <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fxp_seq_divider.sv
// Randomised and directed bench for fxp_seq_divider (WIDTH=32, FBITS=8) against
// a plain-arithmetic quotient model.
module tb_fxp_seq_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, valid, dbz;
  logic [31:0] val;

  int n_checks = 0;
  int n_errors = 0;
  logic [33:0] exp_q[$];

  fxp_seq_divider #(.WIDTH(32), .FBITS(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .valid(valid), .dbz(dbz), .val(val)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {dbz, valid, val} from signed arithmetic on the real values.
  function automatic logic [33:0] model(input logic [31:0] a_i, input logic [31:0] b_i);
    longint num, den, q;
    if (b_i == 32'h0) return {1'b1, 1'b0, 32'h0};
    num = longint'($signed(a_i)) * 256;
    den = longint'($signed(b_i));
    q = num / den;
    if (q > 64'sd2147483647 || q < -64'sd2147483648) return {2'b00, 32'h0};
    return {1'b0, 1'b1, q[31:0]};
  endfunction

  // Starts an op on the current negedge and returns at the negedge where done is seen.
  task automatic run_op(input logic [31:0] aa, input logic [31:0] bb, input bit mid_pulse);
    int lat;
    int bcnt;
    int exp_lat;
    logic [33:0] exp;
    exp_q.push_back(model(aa, bb));
    exp_lat = (bb == 32'h0) ? 1 : 41;
    a = aa;
    b = bb;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    check("start_clr", 64'({valid, dbz}), 64'(0));
    check("done_pulse", 64'(done), 64'(0));
    lat = 0;
    bcnt = 0;
    while (!done && lat < 200) begin
      if (busy) bcnt++;
      start = (mid_pulse && (lat == 5 || lat == 20)) ? 1'b1 : 1'b0;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    start = 1'b0;
    check("latency", 64'(lat), 64'(exp_lat));
    check("busy_cycles", 64'(bcnt), 64'(exp_lat));
    check("busy_at_done", 64'(busy), 64'(0));
    exp = exp_q.pop_front();
    check("result", 64'({dbz, valid, val}), 64'(exp));
  endtask

  task automatic count_idle_done(input int cycles, output int n_done);
    n_done = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
  endtask

  initial begin
    int n_done;
    logic [31:0] ra, rb;
    int kind;

    // reset
    repeat (3) @(negedge clk);
    check("reset_state", 64'({busy, done, valid, dbz, val}), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // directed vectors, issued back to back
    run_op(32'h00000300, 32'h00000200, 1'b0);
    check("dir_3_div_2", 64'(val), 64'h180);
    run_op(32'hFFFFFD00, 32'h00000200, 1'b0);
    check("dir_m3_div_2", 64'(val), 64'hFFFFFE80);
    run_op(32'h00000100, 32'hFFFFFD00, 1'b0);
    check("dir_1_div_m3", 64'(val), 64'hFFFFFFAB);
    run_op(32'h00000100, 32'h00000300, 1'b0);
    check("dir_1_div_3", 64'(val), 64'h55);
    run_op(32'hFFFFFF00, 32'h00000300, 1'b0);
    check("dir_m1_div_3", 64'(val), 64'hFFFFFFAB);
    run_op(32'h12345678, 32'h00000000, 1'b0);
    check("dir_dbz", 64'({dbz, valid, val}), 64'({2'b10, 32'h0}));
    run_op(32'h00000300, 32'h00000200, 1'b0);
    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0);
    check("dir_ovf", 64'({dbz, valid, val}), 64'(0));
    run_op(32'h80000000, 32'h00000100, 1'b0);
    run_op(32'h80000000, 32'hFFFFFF00, 1'b0);
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b0);
    run_op(32'h00000000, 32'hFFFFFF00, 1'b0);

    // starts while busy must be ignored
    run_op(32'h00000500, 32'h00000200, 1'b1);
    count_idle_done(45, n_done);
    check("extra_done", 64'(n_done), 64'(0));

    // reset mid-operation
    a = 32'h00000700;
    b = 32'h00000300;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("reset_mid_op", 64'({busy, done, valid, dbz, val}), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    count_idle_done(50, n_done);
    check("no_done_after_rst", 64'(n_done), 64'(0));
    run_op(32'hFFFFF900, 32'h00000300, 1'b0);

    // randomised operands
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      ra = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) ra = -ra;
      if (kind == 0) rb = 32'h0;
      else if (kind <= 3) rb = $urandom_range(1, 255);
      else rb = ($urandom >> $urandom_range(0, 24)) | 32'h1;
      if ($urandom_range(0, 1) == 1) rb = -rb;
      run_op(ra, rb, 1'b0);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
